// File: rtl/mips_exc_pkg.sv
// Shared types and constants for the exception entry/exit sequencer.
package mips_exc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    VECTOR = 3'd2,
    RET    = 3'd3,
    DRAIN  = 3'd4
  } exc_state_e;

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  localparam logic [31:0] HANDLER_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/exc_seq.sv
// Exception entry/exit sequencer: saves EPC/sets EXL on interrupt, clears EXL on ERET,
// redirects fetch and stalls while draining. EXC_COUNT_EN adds a taken-interrupt counter.
module exc_seq
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_done,
  input  logic        int_req,
  input  logic        is_eret,
  input  logic [29:0] pc_next,
  input  logic [29:0] epc,
  output logic        seq_own,
  output logic        cp0_wen,
  output logic [4:0]  cp0_sel,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        epc_wr,
  output logic [29:0] epc_val,
  output logic        redirect,
  output logic [29:0] redirect_pc,
  output logic        stall,
  output logic [31:0] int_count
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);

  exc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [29:0]      epc_val_q, epc_val_d;

  // State, drain counter and captured return PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      epc_val_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_val_q <= epc_val_d;
    end
  end

  // Next-state logic; ERET takes priority over a pending interrupt at the same boundary.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_val_d = epc_val_q;
    unique case (state_q)
      IDLE: begin
        if (instr_done) begin
          if (is_eret) begin
            state_d = RET;
          end else if (int_req) begin
            state_d   = SAVE;
            epc_val_d = pc_next;
          end
        end
      end
      SAVE: state_d = VECTOR;
      VECTOR, RET: begin
        if (FLUSH_CYCLES > 0) begin
          cnt_d   = CNT_LOAD;
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  assign seq_own     = (state_q == SAVE) || (state_q == RET);
  assign cp0_wen     = seq_own;
  assign cp0_sel     = seq_own ? SEL_EPC : 5'd0;
  assign exl_set     = (state_q == SAVE);
  assign epc_wr      = (state_q == SAVE);
  assign exl_clr     = (state_q == RET);
  assign redirect    = (state_q == VECTOR) || (state_q == RET);
  assign redirect_pc = (state_q == VECTOR) ? HANDLER_ADDR[31:2] :
                       (state_q == RET)    ? epc : 30'd0;
  assign stall       = (state_q != IDLE);
  assign epc_val     = epc_val_q;

`ifdef EXC_COUNT_EN
  logic [31:0] int_cnt_q, int_cnt_d;

  always_comb begin
    int_cnt_d = int_cnt_q;
    if ((state_q == IDLE) && (state_d == SAVE)) int_cnt_d = int_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_cnt_q <= '0;
    else     int_cnt_q <= int_cnt_d;
  end

  assign int_count = int_cnt_q;
`else
  assign int_count = 32'b0;
`endif

endmodule

// File: tb/tb_exc_seq.sv
// Directed self-checking bench for exc_seq (default FLUSH_CYCLES=2 and a FLUSH_CYCLES=0 instance).
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_done = 1'b0, int_req = 1'b0, is_eret = 1'b0;
  logic [29:0] pc_next = '0, epc = '0;
  logic        seq_own, cp0_wen, exl_set, exl_clr, epc_wr, redirect, stall;
  logic [4:0]  cp0_sel;
  logic [29:0] epc_val, redirect_pc;
  logic [31:0] int_count;

  logic        d0_instr_done = 1'b0, d0_int_req = 1'b0, d0_is_eret = 1'b0;
  logic [29:0] d0_pc_next = '0, d0_epc = '0;
  logic        d0_seq_own, d0_cp0_wen, d0_exl_set, d0_exl_clr, d0_epc_wr, d0_redirect, d0_stall;
  logic [4:0]  d0_cp0_sel;
  logic [29:0] d0_epc_val, d0_redirect_pc;
  logic [31:0] d0_int_count;

  int errors = 0;
  int checks = 0;
  int taken  = 0;

  always #5 clk = ~clk;

  exc_seq u_dut (
    .clk(clk), .rst(rst), .instr_done(instr_done), .int_req(int_req), .is_eret(is_eret),
    .pc_next(pc_next), .epc(epc), .seq_own(seq_own), .cp0_wen(cp0_wen), .cp0_sel(cp0_sel),
    .exl_set(exl_set), .exl_clr(exl_clr), .epc_wr(epc_wr), .epc_val(epc_val),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .int_count(int_count)
  );

  exc_seq #(.FLUSH_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .instr_done(d0_instr_done), .int_req(d0_int_req),
    .is_eret(d0_is_eret), .pc_next(d0_pc_next), .epc(d0_epc), .seq_own(d0_seq_own),
    .cp0_wen(d0_cp0_wen), .cp0_sel(d0_cp0_sel), .exl_set(d0_exl_set), .exl_clr(d0_exl_clr),
    .epc_wr(d0_epc_wr), .epc_val(d0_epc_val), .redirect(d0_redirect),
    .redirect_pc(d0_redirect_pc), .stall(d0_stall), .int_count(d0_int_count)
  );

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef EXC_COUNT_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({seq_own, cp0_wen, exl_set, exl_clr, epc_wr, redirect, stall} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {seq_own, cp0_wen, exl_set, exl_clr, epc_wr, redirect, stall});
    end
    checks++;
    if ({cp0_sel, epc_val, redirect_pc, int_count} !== 97'd0) begin
      errors++;
      $display("FAIL reset_values: sel=%0d epc_val=%h rpc=%h cnt=%0d expected all 0",
               cp0_sel, epc_val, redirect_pc, int_count);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall: got %b expected 0", stall); end
  endtask

  task automatic test_interrupt();
    instr_done = 1'b1; int_req = 1'b1; pc_next = 30'h0000_0C04;
    tick();
    instr_done = 1'b0; int_req = 1'b0; pc_next = 30'h0;
    taken++;
    checks++;
    if ({seq_own, cp0_wen, epc_wr, exl_set, exl_clr, redirect, stall} !== 7'b1111001) begin
      errors++;
      $display("FAIL save_strobes: got %b expected 1111001",
               {seq_own, cp0_wen, epc_wr, exl_set, exl_clr, redirect, stall});
    end
    checks++;
    if (cp0_sel !== 5'd14) begin errors++; $display("FAIL save_sel: got %0d expected 14", cp0_sel); end
    checks++;
    if (epc_val !== 30'h0C04) begin errors++; $display("FAIL save_epc_val: got %h expected 0c04", epc_val); end
    tick();
    checks++;
    if ({redirect, stall, seq_own, cp0_wen} !== 4'b1100) begin
      errors++;
      $display("FAIL vector_strobes: got %b expected 1100", {redirect, stall, seq_own, cp0_wen});
    end
    checks++;
    if (redirect_pc !== 30'h1060) begin errors++; $display("FAIL vector_pc: got %h expected 1060", redirect_pc); end
    checks++;
    if (cp0_sel !== 5'd0) begin errors++; $display("FAIL vector_sel: got %0d expected 0", cp0_sel); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({stall, redirect} !== 2'b10) begin
        errors++;
        $display("FAIL drain_%0d: stall/redirect got %b expected 10", i, {stall, redirect});
      end
    end
    tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL int_back_idle: stall got %b expected 0", stall); end
    checks++;
    if (int_count !== exp_cnt(taken)) begin
      errors++;
      $display("FAIL int_count_1: got %0d expected %0d", int_count, exp_cnt(taken));
    end
  endtask

  task automatic test_eret();
    instr_done = 1'b1; is_eret = 1'b1; epc = 30'h0000_0C04;
    tick();
    instr_done = 1'b0; is_eret = 1'b0;
    checks++;
    if ({exl_clr, exl_set, epc_wr, redirect, seq_own, cp0_wen, stall} !== 7'b1001111) begin
      errors++;
      $display("FAIL ret_strobes: got %b expected 1001111",
               {exl_clr, exl_set, epc_wr, redirect, seq_own, cp0_wen, stall});
    end
    checks++;
    if (redirect_pc !== 30'h0C04) begin errors++; $display("FAIL ret_pc: got %h expected 0c04", redirect_pc); end
    checks++;
    if (cp0_sel !== 5'd14) begin errors++; $display("FAIL ret_sel: got %0d expected 14", cp0_sel); end
    epc = 30'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({stall, redirect, exl_clr} !== 3'b100) begin
        errors++;
        $display("FAIL ret_drain_%0d: got %b expected 100", i, {stall, redirect, exl_clr});
      end
    end
    tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ret_back_idle: stall got %b expected 0", stall); end
  endtask

  task automatic test_eret_priority();
    instr_done = 1'b1; is_eret = 1'b1; int_req = 1'b1; epc = 30'h0000_2000;
    tick();
    instr_done = 1'b0; is_eret = 1'b0; int_req = 1'b0;
    checks++;
    if ({exl_clr, exl_set} !== 2'b10) begin
      errors++;
      $display("FAIL prio_ret: exl_clr/exl_set got %b expected 10", {exl_clr, exl_set});
    end
    checks++;
    if (redirect_pc !== 30'h2000) begin errors++; $display("FAIL prio_pc: got %h expected 2000", redirect_pc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (exl_set !== 1'b0) begin errors++; $display("FAIL prio_no_set_%0d: got %b expected 0", i, exl_set); end
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL prio_idle: stall got %b expected 0", stall); end
  endtask

  task automatic test_no_boundary();
    int_req = 1'b1; instr_done = 1'b0; is_eret = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({stall, seq_own, redirect} !== 3'b000) begin
        errors++;
        $display("FAIL no_boundary_%0d: got %b expected 000", i, {stall, seq_own, redirect});
      end
    end
    int_req = 1'b0;
  endtask

  task automatic test_int_drop();
    instr_done = 1'b1; int_req = 1'b1; pc_next = 30'h0000_0040;
    tick();
    instr_done = 1'b0; int_req = 1'b0;
    taken++;
    checks++;
    if (exl_set !== 1'b1) begin errors++; $display("FAIL drop_save: exl_set got %b expected 1", exl_set); end
    tick();
    checks++;
    if ({redirect, redirect_pc} !== {1'b1, 30'h1060}) begin
      errors++;
      $display("FAIL drop_vector: redirect=%b pc=%h expected 1/1060", redirect, redirect_pc);
    end
    tick(); tick(); tick();
    checks++;
    if (int_count !== exp_cnt(taken)) begin
      errors++;
      $display("FAIL int_count_2: got %0d expected %0d", int_count, exp_cnt(taken));
    end
  endtask

  task automatic test_reset_mid_drain();
    instr_done = 1'b1; int_req = 1'b1; pc_next = 30'h0000_0100;
    tick();
    instr_done = 1'b0; int_req = 1'b0;
    tick(); tick();
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_drain: stall got %b expected 1", stall); end
    #2 rst = 1'b1;
    #1;
    taken = 0;
    checks++;
    if ({seq_own, cp0_wen, exl_set, exl_clr, epc_wr, redirect, stall} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_strobes: got %b expected 0000000",
               {seq_own, cp0_wen, exl_set, exl_clr, epc_wr, redirect, stall});
    end
    checks++;
    if ({cp0_sel, epc_val, redirect_pc, int_count} !== 97'd0) begin
      errors++;
      $display("FAIL async_reset_values: sel=%0d epc_val=%h rpc=%h cnt=%0d expected all 0",
               cp0_sel, epc_val, redirect_pc, int_count);
    end
    #2 rst = 1'b0;
    tick(); tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL after_reset_idle: stall got %b expected 0", stall); end
  endtask

  task automatic test_flush0();
    for (int n = 1; n <= 3; n++) begin
      d0_instr_done = 1'b1; d0_int_req = 1'b1; d0_pc_next = 30'(n * 4);
      tick();
      d0_instr_done = 1'b0; d0_int_req = 1'b0;
      checks++;
      if ({d0_exl_set, d0_stall, d0_epc_val} !== {2'b11, 30'(n * 4)}) begin
        errors++;
        $display("FAIL f0_save_%0d: exl_set=%b stall=%b epc_val=%h expected 1/1/%h",
                 n, d0_exl_set, d0_stall, d0_epc_val, 30'(n * 4));
      end
      tick();
      checks++;
      if ({d0_redirect, d0_redirect_pc} !== {1'b1, 30'h1060}) begin
        errors++;
        $display("FAIL f0_vector_%0d: redirect=%b pc=%h expected 1/1060", n, d0_redirect, d0_redirect_pc);
      end
      tick();
      checks++;
      if ({d0_stall, d0_redirect} !== 2'b00) begin
        errors++;
        $display("FAIL f0_idle_%0d: stall/redirect got %b expected 00", n, {d0_stall, d0_redirect});
      end
    end
    checks++;
    if (d0_int_count !== exp_cnt(3)) begin
      errors++;
      $display("FAIL f0_int_count: got %0d expected %0d", d0_int_count, exp_cnt(3));
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_eret();
    test_eret_priority();
    test_no_boundary();
    test_int_drop();
    test_reset_mid_drain();
    test_flush0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
